// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 serial receiver with mid-bit oversampling.
// The line is synchronized, the start bit is checked near its middle,
// and each data/stop bit is then sampled one bit period later. Good bytes
// produce a one-cycle data_valid pulse. A low stop bit produces a one-cycle
// frame_error pulse, and the receiver then waits for the line to go high.
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       system_clock,
    input  logic       rst,
    input  logic       sample_enable,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_s;

    state_t           state_r,       state_nxt_s;
    logic [CNT_W-1:0] sample_cnt_r,  sample_cnt_nxt_s;
    logic [2:0]       bit_idx_r,     bit_idx_nxt_s;
    logic [7:0]       shift_r,       shift_nxt_s;
    logic [7:0]       data_out_r,    data_out_nxt_s;
    logic             data_valid_r,  data_valid_nxt_s;
    logic             frame_error_r, frame_error_nxt_s;
    logic             rx_busy_r,     rx_busy_nxt_s;

    // Two-flop synchronizer for the asynchronous line; runs every clock.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // Next-state, counter, shift and output-pulse logic; advances only on ticks.
    always_comb begin
        state_nxt_s       = state_r;
        sample_cnt_nxt_s  = sample_cnt_r;
        bit_idx_nxt_s     = bit_idx_r;
        shift_nxt_s       = shift_r;
        data_out_nxt_s    = data_out_r;
        data_valid_nxt_s  = 1'b0;
        frame_error_nxt_s = 1'b0;

        if (sample_enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_nxt_s      = ST_START;
                        sample_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        state_nxt_s      = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (sample_cnt_r == CNT_HALF_LAST) begin
                        sample_cnt_nxt_s = CNT_ZERO;
                        if (!rx_s) begin
                            state_nxt_s   = ST_DATA;
                            bit_idx_nxt_s = 3'd0;
                        end else begin
                            // Start bit did not persist to mid-bit: glitch.
                            state_nxt_s   = ST_IDLE;
                        end
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (sample_cnt_r == CNT_FULL_LAST) begin
                        shift_nxt_s      = {rx_s, shift_r[7:1]};
                        sample_cnt_nxt_s = CNT_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            state_nxt_s   = ST_STOP;
                        end else begin
                            bit_idx_nxt_s = bit_idx_r + 3'd1;
                        end
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (sample_cnt_r == CNT_FULL_LAST) begin
                        sample_cnt_nxt_s = CNT_ZERO;
                        if (rx_s) begin
                            data_out_nxt_s    = shift_r;
                            data_valid_nxt_s  = 1'b1;
                            state_nxt_s       = ST_IDLE;
                        end else begin
                            frame_error_nxt_s = 1'b1;
                            state_nxt_s       = ST_WAIT_HIGH;
                        end
                    end else begin
                        sample_cnt_nxt_s = sample_cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low (break) line must not start a new frame.
                    if (rx_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_nxt_s      = ST_IDLE;
                    sample_cnt_nxt_s = CNT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        rx_busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, datapath and registered output flops with synchronous reset.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            sample_cnt_r  <= CNT_ZERO;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            data_out_r    <= 8'h00;
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            rx_busy_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            sample_cnt_r  <= sample_cnt_nxt_s;
            bit_idx_r     <= bit_idx_nxt_s;
            shift_r       <= shift_nxt_s;
            data_out_r    <= data_out_nxt_s;
            data_valid_r  <= data_valid_nxt_s;
            frame_error_r <= frame_error_nxt_s;
            rx_busy_r     <= rx_busy_nxt_s;
        end
    end

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
    assign frame_error = frame_error_r;
    assign rx_busy     = rx_busy_r;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed, table-driven bench for uart_rx_fsm.
// The bench plays the transmitter: each bit lasts a fixed number of clocks
// (OVERSAMPLE x nominal tick spacing), while sample_enable ticks either
// regularly or with balanced +/-1 cycle jitter.
module tb_uart_rx_fsm;

    localparam int OS      = 16;
    localparam int TICK    = 4;
    localparam int BIT_CYC = OS * TICK;

    logic       system_clock;
    logic       rst;
    logic       sample_enable;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       rx_busy;

    uart_rx_fsm #(.OVERSAMPLE(OS)) dut (
        .system_clock  (system_clock),
        .rst           (rst),
        .sample_enable (sample_enable),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .frame_error   (frame_error),
        .rx_busy       (rx_busy)
    );

    typedef struct {
        logic [7:0] tx_byte;
        logic       stop_bit;
        logic       jitter;
        logic [7:0] exp_data;
        int         exp_dv;
        int         exp_fe;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         dv_cnt = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    int         long_cnt = 0;
    logic       jitter_mode = 1'b0;
    logic [7:0] rx_q[$];

    // Free-running clock.
    initial begin
        system_clock = 1'b0;
        forever #5 system_clock = ~system_clock;
    end

    // Tick generator: regular spacing, or balanced 3/5 pairs when jittered.
    initial begin
        int gap;
        int first;
        logic phase;
        sample_enable = 1'b0;
        phase = 1'b0;
        first = TICK;
        forever begin
            if (jitter_mode) begin
                if (!phase) begin
                    first = ($urandom_range(0, 1) == 0) ? TICK - 1 : TICK + 1;
                    gap   = first;
                end else begin
                    gap   = 2 * TICK - first;
                end
                phase = ~phase;
            end else begin
                gap = TICK;
            end
            repeat (gap - 1) @(negedge system_clock);
            sample_enable = 1'b1;
            @(negedge system_clock);
            sample_enable = 1'b0;
        end
    end

    // Output monitor: counts pulses and records received bytes.
    initial begin
        logic dv_prev;
        logic fe_prev;
        dv_prev = 1'b0;
        fe_prev = 1'b0;
        forever begin
            @(negedge system_clock);
            if (data_valid) begin
                dv_cnt++;
                rx_q.push_back(data_out);
            end
            if (frame_error) fe_cnt++;
            if (data_valid && frame_error) both_cnt++;
            if ((data_valid && dv_prev) || (frame_error && fe_prev)) long_cnt++;
            dv_prev = data_valid;
            fe_prev = frame_error;
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic hold_bits(input int nbits);
        repeat (nbits * BIT_CYC) @(negedge system_clock);
    endtask

    // Drive one 8N1 frame; rx is left at the stop-bit value.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        hold_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold_bits(1);
        end
        rx = stop;
        hold_bits(1);
    endtask

    initial begin
        vec_t vecs[7];
        int   dv0;
        int   fe0;
        int   qn;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 8'h01, 1, 0};
        vecs[2] = '{8'h80, 1'b1, 1'b0, 8'h80, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 1, 0};
        vecs[5] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1, 0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge system_clock);
        rst = 1'b0;
        @(negedge system_clock);
        check("reset_data_out",    data_out,    8'h00);
        check("reset_data_valid",  data_valid,  1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        check("reset_rx_busy",     rx_busy,     1'b0);
        hold_bits(1);

        // Table-driven frames: clean bytes, then jittered loopback bytes.
        for (int v = 0; v < 7; v++) begin
            jitter_mode = vecs[v].jitter;
            dv0 = dv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].tx_byte, vecs[v].stop_bit);
            rx = 1'b1;
            hold_bits(1);
            check($sformatf("vec%0d_data_out", v), data_out,      vecs[v].exp_data);
            check($sformatf("vec%0d_valid",    v), dv_cnt - dv0,  vecs[v].exp_dv);
            check($sformatf("vec%0d_ferr",     v), fe_cnt - fe0,  vecs[v].exp_fe);
            check($sformatf("vec%0d_busy",     v), rx_busy,       1'b0);
        end
        jitter_mode = 1'b0;
        check("loopback_order", {rx_q[3], rx_q[4], rx_q[5], rx_q[6]}, 32'h0055AAFF);

        // Glitch: 4 ticks low, then high, must be rejected.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4 * TICK) @(negedge system_clock);
        rx = 1'b1;
        hold_bits(1);
        check("glitch_valid",    dv_cnt - dv0, 0);
        check("glitch_ferr",     fe_cnt - fe0, 0);
        check("glitch_busy",     rx_busy,      1'b0);
        check("glitch_data_out", data_out,     8'hFF);

        // Bad stop bit after a good byte, line held low as a break.
        send_frame(8'hA5, 1'b1);
        rx = 1'b1;
        hold_bits(1);
        check("pre_badstop_data", data_out, 8'hA5);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40 * TICK) @(negedge system_clock);
        check("badstop_ferr",     fe_cnt - fe0, 1);
        check("badstop_valid",    dv_cnt - dv0, 0);
        check("badstop_data_out", data_out,     8'hA5);
        check("badstop_busy",     rx_busy,      1'b1);
        rx = 1'b1;
        hold_bits(1);
        check("badstop_busy_release", rx_busy, 1'b0);
        send_frame(8'h5A, 1'b1);
        rx = 1'b1;
        hold_bits(1);
        check("after_badstop_data",  data_out,     8'h5A);
        check("after_badstop_valid", dv_cnt - dv0, 1);
        check("after_badstop_ferr",  fe_cnt - fe0, 1);

        // Back-to-back frames with no idle bits.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        qn  = rx_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        rx = 1'b1;
        hold_bits(1);
        check("b2b_valid", dv_cnt - dv0, 2);
        check("b2b_ferr",  fe_cnt - fe0, 0);
        if (rx_q.size() >= qn + 2) begin
            check("b2b_first",  rx_q[qn],     8'h00);
            check("b2b_second", rx_q[qn + 1], 8'hFF);
        end else begin
            check("b2b_queue_depth", rx_q.size(), qn + 2);
        end

        // Reset after the 4th data bit of 0x81, then a clean 0xC3.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        hold_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h81 >> i) & 8'h01) != 8'h00;
            hold_bits(1);
        end
        check("midframe_busy", rx_busy, 1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge system_clock);
        rst = 1'b0;
        check("rst_data_out",    data_out,    8'h00);
        check("rst_data_valid",  data_valid,  1'b0);
        check("rst_frame_error", frame_error, 1'b0);
        check("rst_rx_busy",     rx_busy,     1'b0);
        hold_bits(2);
        check("rst_no_pulse",  dv_cnt - dv0, 0);
        check("rst_no_ferr",   fe_cnt - fe0, 0);
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        hold_bits(1);
        check("post_rst_data",  data_out,     8'hC3);
        check("post_rst_valid", dv_cnt - dv0, 1);

        check("valid_ferr_overlap", both_cnt, 0);
        check("pulse_width",        long_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Serial UART receiver: the downstream counterpart of the UART transmit controller. It recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from an asynchronous serial line. It oversamples the line on a shared clock-enable tick, presents each good byte with a one-cycle valid pulse, and flags bad stop bits. It sits between the board RX pin and the byte-consuming logic (display/loopback path).

## Interface
- OVERSAMPLE, 16, sample_enable ticks per bit period; even, ≥4
- system_clock  input  1  sole clock; all flops rising-edge
- rst  input  1  synchronous, active-high reset; priority over all other inputs
- sample_enable  input  1  one-cycle tick at OVERSAMPLE × baud; all state advances only on cycles where it is 1
- rx  input  1  asynchronous serial line, idle high
- data_out  output  8  last correctly received byte; reset 8'h00
- data_valid  output  1  one-cycle pulse when data_out updates; reset 0
- frame_error  output  1  one-cycle pulse on bad stop bit; reset 0
- rx_busy  output  1  high in every state except IDLE; reset 0

## Operation
- rx passes through a 2-flop synchronizer clocked every system_clock cycle (independent of sample_enable); both flops reset to 1. rx_s is the synchronized value.
- Counters: sample_cnt, width clog2(OVERSAMPLE); bit_idx, 3 bits; shift register, 8 bits. On a tick, a counter either increments or is cleared to 0, as stated per state.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. All transitions happen only on sample_enable ticks.
- IDLE: on a tick with rx_s==0 → START, sample_cnt=0.
- START: on a tick, if sample_cnt==OVERSAMPLE/2-1:
  - rx_s==0 → DATA, sample_cnt=0, bit_idx=0
  - rx_s==1 → IDLE (glitch reject; no outputs)
  - otherwise sample_cnt++.
- DATA: on a tick, if sample_cnt==OVERSAMPLE-1:
  - shift = {rx_s, shift[7:1]}, sample_cnt=0
  - if bit_idx==7 → STOP, else bit_idx++.
  - Otherwise sample_cnt++.
- STOP: on a tick, if sample_cnt==OVERSAMPLE-1:
  - rx_s==1 → data_out=shift, data_valid=1, → IDLE
  - rx_s==0 → frame_error=1, data_out unchanged, → WAIT_HIGH
  - otherwise sample_cnt++.
- WAIT_HIGH: on a tick with rx_s==1 → IDLE. A held-low (break) line never starts a new frame.
- data_valid and frame_error are registered. Each is high for exactly one system_clock cycle, then cleared regardless of sample_enable. They are never high together.
- No receive handshake: the consumer must capture data_out on data_valid. data_out holds its value until the next good frame.
- rst in any state: → IDLE, counters and shift cleared, all outputs to reset values, no pulse emitted.
- sample_enable held low: all state frozen (the synchronizer still runs).

## Timing
- Synchronizer latency: 2 system_clock cycles from rx to rx_s.
- Start detection: up to 1 tick late. The start-bit check falls OVERSAMPLE/2 ticks after detection, near mid-bit. Each data/stop sample falls OVERSAMPLE ticks after the previous one.
- data_valid / frame_error: asserted in the system_clock cycle immediately after the stop-bit sampling tick.
- Back-to-back frames: the FSM returns to IDLE at the mid-stop sample, so a start bit immediately following the stop bit is detected. No idle gap is required.
- rx_busy goes high the cycle after the detection tick and low the cycle after the IDLE-entry tick.

## Test plan
- Clean byte: OVERSAMPLE=16, send 0xA5 (8N1) → exactly one data_valid pulse; data_out=0xA5; frame_error=0; rx_busy low after the stop bit.
- Glitch: rx low for 4 ticks, then high → no data_valid, no frame_error; FSM back in IDLE; data_out unchanged.
- Bad stop: after 0xA5, send 0x3C with stop bit 0, holding rx low 40 more ticks → one frame_error pulse; data_out stays 0xA5; rx_busy stays 1 until rx returns high; then 0x5A is received correctly.
- Back-to-back: 0x00 then 0xFF with no idle bits → two data_valid pulses, data_out 0x00 then 0xFF, no frame_error.
- Reset mid-frame: assert rst for 1 cycle after the 4th data bit of 0x81 → all outputs 0 and no pulse; the next frame 0xC3 yields data_out=0xC3.
- Loopback: feed from the UART transmitter using the same baud. Send 0x00, 0x55, 0xAA, 0xFF, with sample_enable jittered ±1 cycle → all four bytes received in order, zero frame errors.
